// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
// Holds the XGA and VGA constant sets, the counter width and the sync pin-level helper.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Pin level for a sync pulse: inverted when the pulse is active-low.
  function automatic logic sync_level(input logic asserted, input logic neg);
    return asserted ^ neg;
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: wrap counter plus active/sync window decode of the post-update count.
// The decode looks at the next count so the parent can register it in the same cycle.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = XGA_H_ACTIVE,
  parameter int FP     = XGA_H_FP,
  parameter int SYNC   = XGA_H_SYNC,
  parameter int BP     = XGA_H_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_wrap,
  output logic             o_active_nxt,
  output logic             o_sync_nxt
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] L_LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] L_ACTIVE = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] L_SYNC_S = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] L_SYNC_E = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;

  assign o_wrap = (r_cnt == L_LAST);

  // Next count: hold, increment, or wrap to zero after the last position.
  always_comb begin
    w_nxt = r_cnt;
    if (i_inc) begin
      if (o_wrap) begin
        w_nxt = {CNT_W{1'b0}};
      end else begin
        w_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_nxt = r_cnt;
    end
  end

  // Counter state; reset parks on the last position so the first step lands on zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= L_LAST;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt_nxt    = w_nxt;
  assign o_active_nxt = (w_nxt < L_ACTIVE);
  assign o_sync_nxt   = (w_nxt >= L_SYNC_S) && (w_nxt < L_SYNC_E);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered pixel position, active/sync decode and frame_tick.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [9:0] frame_cnt
`endif
);

  if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_params
    $error("vga_timing_gen: porch and sync widths must all be non-zero");
  end

  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_h_wrap;
  logic             w_unused_v_wrap;
  logic             w_h_active;
  logic             w_v_active;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_v_inc;
  logic             w_frame_start;

  assign w_v_inc = ce & w_h_wrap;

  vga_axis_ctr #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_ctr (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_inc       (ce),
    .o_cnt_nxt   (w_h_nxt),
    .o_wrap      (w_h_wrap),
    .o_active_nxt(w_h_active),
    .o_sync_nxt  (w_h_sync)
  );

  vga_axis_ctr #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_ctr (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_inc       (w_v_inc),
    .o_cnt_nxt   (w_v_nxt),
    .o_wrap      (w_unused_v_wrap),
    .o_active_nxt(w_v_active),
    .o_sync_nxt  (w_v_sync)
  );

  // h only reaches zero through a wrap, so this marks entry to the first blank line.
  assign w_frame_start = (w_h_nxt == {CNT_W{1'b0}}) && (w_v_nxt == CNT_W'(V_ACTIVE));

  // Output registers: load the post-update decode on ce, otherwise hold with tick cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_x        <= 10'd0;
      pix_y        <= 10'd0;
      video_active <= 1'b0;
      hsync        <= sync_level(1'b0, SYNC_NEG);
      vsync        <= sync_level(1'b0, SYNC_NEG);
      frame_tick   <= 1'b0;
    end else if (ce) begin
      pix_x        <= w_h_nxt[9:0];
      pix_y        <= w_v_nxt[9:0];
      video_active <= w_h_active & w_v_active;
      hsync        <= sync_level(w_h_sync, SYNC_NEG);
      vsync        <= sync_level(w_v_sync, SYNC_NEG);
      frame_tick   <= w_frame_start;
    end else begin
      frame_tick   <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter advances in the same cycle frame_tick is raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= 10'd0;
    end else if (ce && w_frame_start) begin
      frame_cnt <= frame_cnt + 10'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: small-geometry instance against a linear-position reference model,
// plus a default-XGA instance checked over the first lines for the XGA boundaries.
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ce;
  logic [9:0] pix_x, pix_y;
  logic       video_active, hsync, vsync, frame_tick;
  logic       rst_n2, ce2;
  logic [9:0] pix_x2, pix_y2;
  logic       video_active2, hsync2, vsync2, frame_tick2;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [9:0] frame_cnt, frame_cnt2;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_NEG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
    .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  vga_timing_gen dut_xga (
    .clk(clk), .rst_n(rst_n2), .ce(ce2),
    .pix_x(pix_x2), .pix_y(pix_y2), .video_active(video_active2),
    .hsync(hsync2), .vsync(vsync2), .frame_tick(frame_tick2)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(frame_cnt2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: linear pixel index since the first ce after reset.
  bit m_started = 1'b0;
  int m_pos     = 0;
  int m_ticks   = 0;

  task automatic step(input bit rst_v, input bit ce_v);
    bit exp_tick;
    int h, v;
    rst_n = rst_v;
    ce    = ce_v;
    @(posedge clk);
    #1;
    exp_tick = 1'b0;
    if (!rst_v) begin
      m_started = 1'b0;
      m_ticks   = 0;
    end else if (ce_v) begin
      if (!m_started) begin
        m_started = 1'b1;
        m_pos     = 0;
      end else begin
        m_pos = (m_pos + 1) % FT;
      end
      if (m_pos == VA * HT) begin
        exp_tick = 1'b1;
        m_ticks++;
      end
    end
    if (!m_started) begin
      check_eq("rst_pix_x", pix_x, 0);
      check_eq("rst_pix_y", pix_y, 0);
      check_eq("rst_active", video_active, 0);
      check_eq("rst_hsync", hsync, 1);
      check_eq("rst_vsync", vsync, 1);
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      check_eq("pix_x", pix_x, h % 1024);
      check_eq("pix_y", pix_y, v % 1024);
      check_eq("active", video_active, (h < HA && v < VA) ? 1 : 0);
      check_eq("hsync", hsync, (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
      check_eq("vsync", vsync, (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
    end
    check_eq("frame_tick", frame_tick, exp_tick);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_eq("frame_cnt", frame_cnt, m_ticks % 1024);
`endif
  endtask

  initial begin
    int first_low, low_cnt, tick_seen, guard;
    rst_n  = 1'b0;
    ce     = 1'b0;
    rst_n2 = 1'b0;
    ce2    = 1'b1;

    // XGA instance: line-level boundaries with ce held high.
    repeat (2) @(posedge clk);
    #1;
    check_eq("xga_rst_active", video_active2, 0);
    check_eq("xga_rst_hsync", hsync2, 1);
    check_eq("xga_rst_vsync", vsync2, 1);
    check_eq("xga_rst_tick", frame_tick2, 0);
    rst_n2    = 1'b1;
    first_low = -1;
    low_cnt   = 0;
    tick_seen = 0;
    for (int i = 0; i < 1400; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        check_eq("xga_first_x", pix_x2, 0);
        check_eq("xga_first_y", pix_y2, 0);
        check_eq("xga_first_active", video_active2, 1);
      end
      if (i == 1023) begin
        check_eq("xga_x1023", pix_x2, 1023);
        check_eq("xga_x1023_active", video_active2, 1);
      end
      if (i == 1024) check_eq("xga_h1024_active", video_active2, 0);
      if (hsync2 == 1'b0) begin
        if (first_low < 0) first_low = i;
        low_cnt++;
      end
      if (frame_tick2) tick_seen++;
    end
    check_eq("xga_hsync_start", first_low, 1048);
    check_eq("xga_hsync_width", low_cnt, 136);
    check_eq("xga_line1_x", pix_x2, 1399 - 1344);
    check_eq("xga_line1_y", pix_y2, 1);
    check_eq("xga_vsync_idle", vsync2, 1);
    check_eq("xga_no_tick", tick_seen, 0);

    // Small geometry: reset, then ce every cycle for several frames.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (6 * FT) step(1'b1, 1'b1);

    // ce one cycle in three, then random ce.
    for (int i = 0; i < 3 * 3 * FT; i++) step(1'b1, (i % 3) == 2);
    repeat (1500) step(1'b1, $urandom_range(0, 1) == 1);

    // Directed mid-frame reset, then idle cycles before the first ce.
    guard = 0;
    while (!(m_pos == HT + 2) && guard < 4 * FT) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check_eq("midframe_reached", m_pos, HT + 2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_eq("post_rst_x", pix_x, 0);
    check_eq("post_rst_y", pix_y, 0);

    // Random ce with occasional random resets.
    repeat (3000) step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Long continuous run so the frame counter wraps 1023 -> 0.
    step(1'b0, 1'b0);
    repeat (1025 * FT + 4) step(1'b1, 1'b1);
    check_eq("frame_cnt_wrapped", m_ticks, 1025);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
